// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths, channel limit and mode encoding for the clock dividers.
package clk_div_pkg;
  localparam int RATIO_W_DEF = 8;
  localparam int N_CH_MAX = 8;
  typedef enum logic {BYPASS = 1'b0, DIVIDE = 1'b1} mode_e;
  function automatic mode_e cfg_mode(input logic en, input logic ratio_ge2);
    return (en && ratio_ge2) ? DIVIDE : BYPASS;
  endfunction
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel; configuration is sampled only at period boundaries.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int RATIO_W = RATIO_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [RATIO_W-1:0] ratio,
  output logic               div_clk,
  output logic               cfg_ack
);
  localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);
  logic               act_en_q, act_en_d;
  logic [RATIO_W-1:0] act_ratio_q, act_ratio_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               ack_q, ack_d;
  logic               load;
  mode_e              mode_cur, mode_in;
  // Ratios 0/1 collapse into bypass, so ack compares effective modes, not raw fields.
  always_comb begin
    mode_cur    = cfg_mode(act_en_q, act_ratio_q > ONE);
    mode_in     = cfg_mode(en, ratio > ONE);
    load        = (mode_cur == BYPASS) || (cnt_q == act_ratio_q - ONE);
    act_en_d    = load ? en : act_en_q;
    act_ratio_d = load ? ratio : act_ratio_q;
    cnt_d       = load ? '0 : cnt_q + ONE;
    div_d       = load ? (mode_in == DIVIDE) : (cnt_d < (act_ratio_q >> 1));
    ack_d       = load && ((mode_in != mode_cur) ||
                           ((mode_in == DIVIDE) && (ratio != act_ratio_q)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_en_q    <= 1'b0;
      act_ratio_q <= '0;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      act_en_q    <= act_en_d;
      act_ratio_q <= act_ratio_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      ack_q       <= ack_d;
    end
  end
  // Select comes only from flops, so the mux never follows raw input changes.
  assign div_clk = (mode_cur == DIVIDE) ? div_q : clk;
  assign cfg_ack = ack_q;
endmodule

// File: rtl/multi_clk_div.sv
// multi_clk_div: N_CH independent reference-clock dividers with boundary-aligned reconfiguration.
module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int RATIO_W = RATIO_W_DEF
) (
  input  logic                    i_clk_ref,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         i_clk_en,
  input  logic [N_CH*RATIO_W-1:0] i_div_ratio,
  output logic [N_CH-1:0]         o_div_clk,
  output logic [N_CH-1:0]         o_cfg_ack
);
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clk_div_ch #(.RATIO_W(RATIO_W)) u_ch (
      .clk     (i_clk_ref),
      .rst_n   (i_rst_n),
      .en      (i_clk_en[c]),
      .ratio   (i_div_ratio[c*RATIO_W +: RATIO_W]),
      .div_clk (o_div_clk[c]),
      .cfg_ack (o_cfg_ack[c])
    );
  end
endmodule

// File: tb/tb_multi_clk_div.sv
// tb_multi_clk_div: directed table and corner-case sequences for multi_clk_div.
module tb_multi_clk_div;
  logic        clk_ref = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic [15:0] ratio;
  logic [1:0]  div_clk;
  logic [1:0]  ack;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk_ref = ~clk_ref;

  multi_clk_div #(.N_CH(2), .RATIO_W(8)) dut (
    .i_clk_ref   (clk_ref),
    .i_rst_n     (rst_n),
    .i_clk_en    (en),
    .i_div_ratio (ratio),
    .o_div_clk   (div_clk),
    .o_cfg_ack   (ack)
  );

  typedef struct {
    logic       en;
    logic [7:0] ratio;
    logic       ack;
    int         hi;
    int         lo;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ref);
    #1;
    cyc++;
  endtask

  task automatic set_ch(input int c, input logic e, input logic [7:0] r);
    en[c] = e;
    ratio[c*8 +: 8] = r;
  endtask

  task automatic wait_ack(input int c, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack[c] && n < 400);
  endtask

  task automatic measure(input int c, output int h, output int l, output int extra);
    h = 0;
    l = 0;
    extra = 0;
    while (div_clk[c] && h < 400) begin
      h++;
      tick();
      if (ack[c]) extra++;
    end
    while (!div_clk[c] && l < 400) begin
      l++;
      tick();
      if (ack[c]) extra++;
    end
  endtask

  task automatic check_bypass(input int c, input string name);
    chk({name, "_hi"}, int'(div_clk[c]), 1);
    #5;
    chk({name, "_lo"}, int'(div_clk[c]), 0);
    tick();
  endtask

  task automatic count_acks(input int c, input int n, output int a);
    a = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ack[c]) a++;
    end
  endtask

  initial begin
    vec_t vecs[10];
    int n, h, l, x, a, k0, k1;
    vecs[0] = '{1'b1, 8'd1,   1'b0, 0,   0};
    vecs[1] = '{1'b1, 8'd0,   1'b0, 0,   0};
    vecs[2] = '{1'b1, 8'd1,   1'b0, 0,   0};
    vecs[3] = '{1'b1, 8'd255, 1'b1, 127, 128};
    vecs[4] = '{1'b1, 8'd3,   1'b1, 1,   2};
    vecs[5] = '{1'b1, 8'd4,   1'b1, 2,   2};
    vecs[6] = '{1'b1, 8'd4,   1'b0, 2,   2};
    vecs[7] = '{1'b0, 8'd4,   1'b1, 0,   0};
    vecs[8] = '{1'b1, 8'd2,   1'b1, 1,   1};
    vecs[9] = '{1'b0, 8'd0,   1'b1, 0,   0};

    rst_n = 1'b0;
    en = '0;
    ratio = '0;
    tick();
    tick();
    chk("rst_byp_hi", int'(div_clk), 3);
    chk("rst_ack", int'(ack), 0);
    #5;
    chk("rst_byp_lo", int'(div_clk), 0);

    set_ch(0, 1'b1, 8'd32);
    rst_n = 1'b1;
    wait_ack(0, n);
    chk("r32_ack_lat", n, 1);
    chk("r32_first_hi", int'(div_clk[0]), 1);
    measure(0, h, l, x);
    chk("r32_high", h, 16);
    chk("r32_low", l, 16);
    chk("r32_no_reack", x, 0);

    for (int i = 0; i < 10; i++) tick();
    set_ch(0, 1'b1, 8'd5);
    wait_ack(0, n);
    chk("r32to5_ack_lat", n, 22);
    measure(0, h, l, x);
    chk("r5_high", h, 2);
    chk("r5_low", l, 3);
    chk("r5_no_reack", x, 0);
    check_bypass(1, "ch1_byp");

    set_ch(0, 1'b1, 8'd4);
    tick();
    set_ch(0, 1'b0, 8'd4);
    chk("r5_low_before_off", int'(div_clk[0]), 0);
    wait_ack(0, n);
    chk("off_ack_lat", n, 3);
    check_bypass(0, "off_byp");
    count_acks(0, 10, a);
    chk("off_single_ack", a, 0);

    for (int i = 0; i < 10; i++) begin
      set_ch(0, vecs[i].en, vecs[i].ratio);
      if (vecs[i].ack) begin
        wait_ack(0, n);
        chk($sformatf("v%0d_ack_seen", i), int'(ack[0]), 1);
        if (vecs[i].hi > 0) begin
          measure(0, h, l, x);
          chk($sformatf("v%0d_high", i), h, vecs[i].hi);
          chk($sformatf("v%0d_low", i), l, vecs[i].lo);
          chk($sformatf("v%0d_no_reack", i), x, 0);
        end else begin
          check_bypass(0, $sformatf("v%0d_byp", i));
        end
      end else begin
        count_acks(0, 40, a);
        chk($sformatf("v%0d_no_ack", i), a, 0);
        if (vecs[i].hi == 0) check_bypass(0, $sformatf("v%0d_byp", i));
      end
    end

    set_ch(0, 1'b1, 8'd6);
    wait_ack(0, n);
    chk("r6_ack_lat", n, 1);
    chk("r6_first_hi", int'(div_clk[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ack", int'(ack[0]), 0);
    chk("midrst_byp_hi", int'(div_clk[0]), 1);
    #4;
    chk("midrst_byp_lo", int'(div_clk[0]), 0);
    rst_n = 1'b1;
    wait_ack(0, n);
    chk("postrst_ack_lat", n, 1);
    measure(0, h, l, x);
    chk("r6_high", h, 3);
    chk("r6_low", l, 3);
    chk("r6_no_reack", x, 0);

    set_ch(0, 1'b1, 8'd3);
    wait_ack(0, n);
    chk("r6to3_ack_lat", n, 6);
    k0 = cyc;
    tick();
    tick();
    set_ch(1, 1'b1, 8'd7);
    wait_ack(1, n);
    chk("ch1_r7_ack_lat", n, 1);
    k1 = cyc;
    a = 0;
    for (int i = 0; i < 42; i++) begin
      tick();
      if (ack != 2'b00) a++;
      chk($sformatf("conc_ch0_c%0d", i), int'(div_clk[0]), int'((cyc - k0) % 3 == 0));
      chk($sformatf("conc_ch1_c%0d", i), int'(div_clk[1]), int'((cyc - k1) % 7 < 3));
    end
    chk("conc_no_ack", a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
